rsa_host_cmd_ctrl: RTL and testbench

Parametrised ARM-to-accelerator command/data controller for the RSA exponentiation datapath. It sits between the ARM-facing command/data ports and the exponentiation engine. It accepts opcode+slot commands, loads operands into an indexed slot file, and starts the engine. It also enforces a compute timeout, reads back results or slots, and reports a per-command status code with the done handshake.

---
 rtl/rsa_host_cmd_ctrl.sv | 171 +++++++++++++++++
 tb/tb_rsa_host_cmd_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_host_cmd_ctrl.sv
// rsa_host_cmd_ctrl
//   Command/data controller between the ARM host ports and the RSA
//   exponentiation engine. It decodes opcode+slot commands, loads operands
//   into a slot file, and starts the engine under a cycle timeout. It also
//   reads back the result or a slot, and reports a status code with done.
//
// Ports
//   clk, resetn               clock, synchronous active-low reset
//   cmd, cmd_valid/cmd_ready  command: [3:0] opcode, [7:4] slot index
//   done, done_read, status   completion flag (held until ack), 2-bit code
//   in_data, in_valid/ready   operand load handshake
//   out_data, out_valid/ready readback handshake
//   slots                     flattened slot file, slot k at [k*DW +: DW]
//   eng_start, eng_rst_n      engine start pulse, engine reset (active low)
//   eng_done, eng_result      engine completion and result
//   leds                      current state encoding
module rsa_host_cmd_ctrl #(
  parameter int          DW     = 1024,
  parameter int          NSLOT  = 8,
  parameter logic [31:0] TO_CYC = 32'd2000000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [31:0]           cmd,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  done,
  input  logic                  done_read,
  output logic [1:0]            status,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic [NSLOT*DW-1:0]   slots,
  output logic                  eng_start,
  output logic                  eng_rst_n,
  input  logic                  eng_done,
  input  logic [DW-1:0]         eng_result,
  output logic [3:0]            leds
);

  localparam int SW = $clog2(NSLOT);

  localparam logic [3:0] OP_NOP      = 4'd0;
  localparam logic [3:0] OP_LOAD     = 4'd1;
  localparam logic [3:0] OP_READ_RES = 4'd2;
  localparam logic [3:0] OP_COMPUTE  = 4'd3;
  localparam logic [3:0] OP_SOFT_RST = 4'd4;
  localparam logic [3:0] OP_READ_SLT = 4'd5;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_BAD_OP   = 2'd1;
  localparam logic [1:0] ST_BAD_SLOT = 2'd2;
  localparam logic [1:0] ST_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_LOAD, S_WRITE, S_START, S_WAIT, S_ABORT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      status_q, status_d;
  logic [7:0]      cmd_q;
  logic [31:0]     cnt_q;
  logic [DW-1:0]   result_q;
  logic [DW-1:0]   slot_q [NSLOT];

  logic [3:0]      op;
  logic [SW-1:0]   idx;
  logic            slot_ok;
  logic            tc;
  logic            unused_cmd;

  assign op         = cmd_q[3:0];
  assign idx        = cmd_q[4 +: SW];
  // Range check on the full 4-bit field; idx alone would alias out-of-range slots.
  assign slot_ok    = 32'(cmd_q[7:4]) < 32'(NSLOT);
  assign tc         = (cnt_q == TO_CYC - 32'd1);
  assign unused_cmd = ^cmd[31:8];

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state and status
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    unique case (state_q)
      S_IDLE:   if (cmd_valid) state_d = S_DECODE;
      S_DECODE: begin
        status_d = ST_OK;
        case (op)
          OP_NOP:      state_d = S_DONE;
          OP_LOAD, OP_READ_SLT: begin
            if (!slot_ok) begin
              state_d  = S_DONE;
              status_d = ST_BAD_SLOT;
            end else begin
              state_d = (op == OP_LOAD) ? S_LOAD : S_WRITE;
            end
          end
          OP_READ_RES: state_d = S_WRITE;
          OP_COMPUTE:  state_d = S_START;
          OP_SOFT_RST: state_d = S_ABORT;
          default: begin
            state_d  = S_DONE;
            status_d = ST_BAD_OP;
          end
        endcase
      end
      S_LOAD:   if (in_valid) state_d = S_DONE;
      S_WRITE:  if (out_ready) state_d = S_DONE;
      S_START:  state_d = S_WAIT;
      S_WAIT: begin
        // eng_done takes priority over a coincident terminal count
        if (eng_done) begin
          state_d = S_DONE;
        end else if (tc) begin
          state_d  = S_ABORT;
          status_d = ST_TIMEOUT;
        end
      end
      S_ABORT:  state_d = S_DONE;
      S_DONE:   if (done_read) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      status_q <= ST_OK;
      cmd_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      for (int k = 0; k < NSLOT; k++) slot_q[k] <= '0;
    end else begin
      status_q <= status_d;
      if (state_q == S_IDLE && cmd_valid) cmd_q <= cmd[7:0];
      if (state_q == S_LOAD && in_valid) slot_q[idx] <= in_data;
      if (state_q == S_START)     cnt_q <= '0;
      else if (state_q == S_WAIT) cnt_q <= cnt_q + 32'd1;
      if (state_q == S_WAIT && eng_done) result_q <= eng_result;
    end
  end

  // Moore outputs
  assign cmd_ready = (state_q == S_IDLE);
  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign eng_start = (state_q == S_START);
  assign eng_rst_n = resetn & (state_q != S_ABORT);
  assign status    = status_q;
  assign leds      = {1'b0, state_q};

  always_comb begin
    out_data = '0;
    if (state_q == S_WRITE)
      out_data = (op == OP_READ_RES) ? result_q : slot_q[idx];
  end

  for (genvar k = 0; k < NSLOT; k++) begin : g_slots
    assign slots[k*DW +: DW] = slot_q[k];
  end

endmodule

// File: tb/tb_rsa_host_cmd_ctrl.sv
module tb_rsa_host_cmd_ctrl;
  localparam int          DW     = 32;
  localparam int          NSLOT  = 4;
  localparam logic [31:0] TO_CYC = 32'd16;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic [31:0]         cmd = '0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic                done;
  logic                done_read = 1'b0;
  logic [1:0]          status;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [DW-1:0]       in_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [DW-1:0]       out_data;
  logic [NSLOT*DW-1:0] slots;
  logic                eng_start;
  logic                eng_rst_n;
  logic                eng_done = 1'b0;
  logic [DW-1:0]       eng_result = '0;
  logic [3:0]          leds;

  always #5 clk = ~clk;

  rsa_host_cmd_ctrl #(.DW(DW), .NSLOT(NSLOT), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .resetn(resetn), .cmd(cmd), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .done(done), .done_read(done_read), .status(status),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .slots(slots), .eng_start(eng_start), .eng_rst_n(eng_rst_n),
    .eng_done(eng_done), .eng_result(eng_result), .leds(leds)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command and follow it to done, then acknowledge.
  logic [1:0]    r_st;
  int            r_lat;
  logic          r_in, r_ov, r_stab;
  logic [DW-1:0] r_od;

  task automatic do_cmd(input logic [3:0] op, input logic [3:0] sl,
                        input logic [DW-1:0] din, input int odly);
    int n, ovc;
    r_in = 0; r_ov = 0; r_stab = 1; r_od = '0; ovc = 0;
    cmd = {24'd0, sl, op}; cmd_valid = 1; in_data = din; in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    cmd_valid = 0; n = 1;
    while (!done && n < 200) begin
      if (in_ready) r_in = 1;
      if (out_valid) begin
        if (!r_ov) r_od = out_data;
        else if (out_data !== r_od) r_stab = 0;
        r_ov = 1; ovc++;
        if (ovc > odly) out_ready = 1;
      end
      @(posedge clk); #1; n++;
    end
    r_lat = n;
    r_st  = status;
    if (!done) chk("done_reached", done, 1);
    in_valid = 0; out_ready = 0; done_read = 1;
    @(posedge clk); #1;
    done_read = 0;
  endtask

  // Engine model: wait for start, then raise eng_done at WAIT cycle dly
  // (dly<0 = silent). Records eng_rst_n lows by WAIT cycle index.
  int          e_starts;
  logic [31:0] e_mask;

  task automatic eng_run(input int dly, input logic [DW-1:0] res);
    int k;
    e_starts = 0; e_mask = '0; k = 0;
    while (!eng_start && k < 20) begin @(posedge clk); #1; k++; end
    if (eng_start) e_starts++;
    @(posedge clk); #1;
    if (eng_start) e_starts++;
    for (int j = 0; j <= 20; j++) begin
      if (!eng_rst_n) e_mask = e_mask | (32'd1 << j);
      eng_done   = (j == dly);
      eng_result = (j == dly) ? res : '0;
      @(posedge clk); #1;
    end
    eng_done = 0; eng_result = '0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  sl;
    logic [31:0] din;
    int          odly;
    logic [1:0]  st;
    int          lat;
    logic        in_rdy;
    logic        ov;
    logic [31:0] od;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{4'd1, 4'd1, 32'h0000_00C5, 0, 2'd0, 3, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{4'd5, 4'd1, 32'h0,         0, 2'd0, 3, 1'b0, 1'b1, 32'h0000_00C5};
    tbl[2]  = '{4'd1, 4'd5, 32'h0000_DEAD, 0, 2'd2, 2, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{4'hE, 4'd0, 32'h0,         0, 2'd1, 2, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{4'd0, 4'd0, 32'h0,         0, 2'd0, 2, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{4'd1, 4'd0, 32'hA5A5_0001, 0, 2'd0, 3, 1'b1, 1'b0, 32'h0};
    tbl[6]  = '{4'd1, 4'd3, 32'hFFFF_FFFF, 0, 2'd0, 3, 1'b1, 1'b0, 32'h0};
    tbl[7]  = '{4'd5, 4'd3, 32'h0,         5, 2'd0, 8, 1'b0, 1'b1, 32'hFFFF_FFFF};
    tbl[8]  = '{4'd5, 4'd4, 32'h0,         0, 2'd2, 2, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{4'd5, 4'd0, 32'h0,         0, 2'd0, 3, 1'b0, 1'b1, 32'hA5A5_0001};
    tbl[10] = '{4'd4, 4'd0, 32'h0,         0, 2'd0, 3, 1'b0, 1'b0, 32'h0};
    tbl[11] = '{4'd2, 4'd9, 32'h0,         0, 2'd0, 3, 1'b0, 1'b1, 32'h0};
    tbl[12] = '{4'd6, 4'd1, 32'h0000_0077, 0, 2'd1, 2, 1'b0, 1'b0, 32'h0};
    tbl[13] = '{4'hF, 4'd2, 32'h0000_0088, 0, 2'd1, 2, 1'b0, 1'b0, 32'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_rst_n", eng_rst_n, 0);
    chk("rst_leds", leds, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_status", status, 0);
    chk("rst_slots", slots, 0);
    resetn = 1;
    @(posedge clk); #1;
    chk("eng_rst_n_rel", eng_rst_n, 1);

    // Directed command vectors
    for (int i = 0; i < 14; i++) begin
      do_cmd(tbl[i].op, tbl[i].sl, tbl[i].din, tbl[i].odly);
      chk($sformatf("v%0d_status", i), r_st, tbl[i].st);
      chk($sformatf("v%0d_latency", i), r_lat, tbl[i].lat);
      chk($sformatf("v%0d_in_ready_seen", i), r_in, tbl[i].in_rdy);
      chk($sformatf("v%0d_out_valid_seen", i), r_ov, tbl[i].ov);
      if (tbl[i].ov) begin
        chk($sformatf("v%0d_out_data", i), r_od, tbl[i].od);
        chk($sformatf("v%0d_out_stable", i), r_stab, 1);
      end
    end
    chk("slot0", slots[0*DW +: DW], 32'hA5A5_0001);
    chk("slot1", slots[1*DW +: DW], 32'h0000_00C5);
    chk("slot2", slots[2*DW +: DW], 32'h0);
    chk("slot3", slots[3*DW +: DW], 32'hFFFF_FFFF);

    // COMPUTE, engine answers at WAIT+10; stray cmd_valid pulsed during WAIT
    fork
      do_cmd(4'd3, 4'd0, '0, 0);
      eng_run(10, 32'h0000_1234);
      begin
        repeat (6) @(posedge clk);
        #1;
        cmd = {24'd0, 4'd2, 4'd1}; cmd_valid = 1;
        repeat (2) @(posedge clk);
        #1;
        cmd_valid = 0;
      end
    join
    chk("cmp_status", r_st, 0);
    chk("cmp_latency", r_lat, 14);
    chk("cmp_start_pulses", e_starts, 1);
    chk("cmp_no_eng_rst", e_mask, 0);
    chk("cmp_idle_after", cmd_ready, 1);
    chk("cmp_no_redone", done, 0);
    do_cmd(4'd2, 4'd0, '0, 0);
    chk("cmp_result", r_od, 32'h0000_1234);

    // Timeout with a silent engine
    fork
      do_cmd(4'd3, 4'd0, '0, 0);
      eng_run(-1, '0);
    join
    chk("to_status", r_st, 3);
    chk("to_latency", r_lat, 20);
    chk("to_eng_rst_mask", e_mask, 32'd1 << 16);
    do_cmd(4'd2, 4'd0, '0, 0);
    chk("to_result_kept", r_od, 32'h0000_1234);

    // eng_done coincident with terminal count
    fork
      do_cmd(4'd3, 4'd0, '0, 0);
      eng_run(15, 32'h0000_BEEF);
    join
    chk("tc_status", r_st, 0);
    chk("tc_latency", r_lat, 19);
    chk("tc_no_eng_rst", e_mask, 0);
    do_cmd(4'd2, 4'd0, '0, 0);
    chk("tc_result", r_od, 32'h0000_BEEF);

    // done_read held high into IDLE
    cmd = 32'h0; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    @(posedge clk); #1;
    chk("hold_done", done, 1);
    done_read = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_idle", {cmd_ready, done}, 2'b10);
    end
    done_read = 0;

    // resetn pulsed during WAIT
    cmd = {24'd0, 4'd0, 4'd3}; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    resetn = 0;
    @(posedge clk); #1;
    chk("mid_cmd_ready", cmd_ready, 1);
    chk("mid_done", done, 0);
    chk("mid_eng_start", eng_start, 0);
    chk("mid_eng_rst_n", eng_rst_n, 0);
    chk("mid_leds", leds, 0);
    chk("mid_status", status, 0);
    chk("mid_slots", slots, 0);
    resetn = 1;
    #1;
    chk("mid_eng_rst_rel", eng_rst_n, 1);
    @(posedge clk); #1;
    do_cmd(4'd2, 4'd0, '0, 0);
    chk("mid_result_cleared", r_od, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
